// File: rtl/fp_convert_int_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_convert_int_pipe_if                                          |
// | Brief    : Handshake bundle for the integer-to-binary32 conversion pipe.   |
// |            out_inexact exists only when FP_CVT_INEXACT_EN is defined.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fp_convert_int_pipe_if #(
  parameter int IN_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            in_signed;
  logic            in_rm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_fp;
`ifdef FP_CVT_INEXACT_EN
  logic            out_inexact;

  modport master (
    output in_valid, in_data, in_signed, in_rm, out_ready,
    input  in_ready, out_valid, out_fp, out_inexact
  );
  modport slave (
    input  in_valid, in_data, in_signed, in_rm, out_ready,
    output in_ready, out_valid, out_fp, out_inexact
  );
`else
  modport master (
    output in_valid, in_data, in_signed, in_rm, out_ready,
    input  in_ready, out_valid, out_fp
  );
  modport slave (
    input  in_valid, in_data, in_signed, in_rm, out_ready,
    output in_ready, out_valid, out_fp
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fp_convert_int_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_convert_int_pipe                                             |
// | Brief    : 3-stage signed/unsigned integer to IEEE-754 binary32 converter  |
// |            (RNE/RTZ) with per-stage valid and bubble collapse.             |
// |            Optional macro FP_CVT_INEXACT_EN adds the out_inexact flag.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fp_convert_int_pipe #(
  parameter int IN_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  fp_convert_int_pipe_if.slave  bus
);

  localparam int c_EXT_W = IN_W + 24;

  logic            rdy_q;
  logic            s1_valid_q, s1_sign_q, s1_rm_q;
  logic [IN_W-1:0] s1_mag_q;
  logic            s2_valid_q, s2_sign_q, s2_rm_q, s2_zero_q;
  logic [IN_W-2:0] s2_frac_q;
  logic [7:0]      s2_exp_q;
  logic            s3_valid_q;
  logic [31:0]     s3_fp_q;

  logic s1_load, s2_load, s3_load;

  assign s3_load = !s3_valid_q || bus.out_ready;
  assign s2_load = !s2_valid_q || s3_load;
  assign s1_load = rdy_q && (!s1_valid_q || s2_load);

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s3_valid_q;
  assign bus.out_fp    = s3_fp_q;

  // S1: two's-complement negate; the most negative value maps to 2^(IN_W-1)
  logic            s1_sign_d;
  logic [IN_W-1:0] s1_mag_d;
  assign s1_sign_d = bus.in_signed & bus.in_data[IN_W-1];
  assign s1_mag_d  = s1_sign_d ? -bus.in_data : bus.in_data;

  logic [6:0]      msb_d;
  logic [6:0]      shamt_d;
  logic [IN_W-1:0] norm_d;
  logic [7:0]      exp_d;

  always_comb begin
    msb_d = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag_q[i]) msb_d = 7'(i);
    end
  end

  assign shamt_d = 7'(IN_W - 1) - msb_d;
  assign norm_d  = s1_mag_q << shamt_d;
  assign exp_d   = 8'(msb_d) + 8'd127;

  // S3: the hidden one is dropped; padding below the fraction feeds guard/sticky
  logic [c_EXT_W-1:0] ext_d;
  logic [22:0]        mant_d;
  logic               guard_d, sticky_d, inc_d;
  logic [23:0]        mant_r_d;
  logic [7:0]         exp_r_d;
  logic [31:0]        fp_d;

  assign ext_d    = {s2_frac_q, 25'd0};
  assign mant_d   = ext_d[c_EXT_W-1 -: 23];
  assign guard_d  = ext_d[c_EXT_W-24];
  assign sticky_d = |ext_d[c_EXT_W-25:0];
  assign inc_d    = !s2_rm_q && guard_d && (sticky_d || mant_d[0]);
  assign mant_r_d = {1'b0, mant_d} + {23'd0, inc_d};
  assign exp_r_d  = s2_exp_q + {7'd0, mant_r_d[23]};
  assign fp_d     = s2_zero_q ? 32'd0 : {s2_sign_q, exp_r_d, mant_r_d[22:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_rm_q    <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_rm_q    <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_frac_q  <= '0;
      s2_exp_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_fp_q    <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_load) begin
        s1_valid_q <= bus.in_valid;
        s1_sign_q  <= s1_sign_d;
        s1_rm_q    <= bus.in_rm;
        s1_mag_q   <= s1_mag_d;
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        s2_sign_q  <= s1_sign_q;
        s2_rm_q    <= s1_rm_q;
        s2_zero_q  <= !norm_d[IN_W-1];
        s2_frac_q  <= norm_d[IN_W-2:0];
        s2_exp_q   <= exp_d;
      end
      if (s3_load) begin
        s3_valid_q <= s2_valid_q;
        s3_fp_q    <= fp_d;
      end
    end
  end

`ifdef FP_CVT_INEXACT_EN
  logic s3_inexact_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_inexact_q <= 1'b0;
    end else if (s3_load) begin
      s3_inexact_q <= guard_d | sticky_d;
    end
  end

  assign bus.out_inexact = s3_inexact_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_convert_int_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fp_convert_int_pipe                                          |
// | Brief    : Scoreboard bench for fp_convert_int_pipe at IN_W = 8, 32, 64.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fp_convert_int_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [32:0] exp_q[$];

`ifdef FP_CVT_INEXACT_EN
  localparam logic [32:0] CMP_MASK = 33'h1_ffff_ffff;
`else
  localparam logic [32:0] CMP_MASK = 33'h0_ffff_ffff;
`endif

  typedef struct {
    logic [31:0] d;
    bit          s;
    bit          rm;
    logic [32:0] e;
  } vec_t;

  fp_convert_int_pipe_if #(.IN_W(32)) bus32 ();
  fp_convert_int_pipe_if #(.IN_W(8))  bus8  ();
  fp_convert_int_pipe_if #(.IN_W(64)) bus64 ();

  fp_convert_int_pipe #(.IN_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  fp_convert_int_pipe #(.IN_W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  fp_convert_int_pipe #(.IN_W(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  always #5 clk = ~clk;

  // Reference: locate the top set bit, then round the discarded remainder against half an ulp
  function automatic logic [32:0] model(input logic [63:0] d, input int w, input bit sgn, input bit rm);
    logic [63:0] mask, x, mag, m, rem, half;
    int p, sh;
    bit neg, up, inx;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x    = d & mask;
    neg  = sgn && x[w-1];
    mag  = neg ? ((~x + 64'd1) & mask) : x;
    if (mag == 64'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    inx = 1'b0;
    if (p <= 23) begin
      m = mag << (23 - p);
    end else begin
      sh   = p - 23;
      m    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      up   = !rm && ((rem > half) || ((rem == half) && m[0]));
      m    = m + {63'd0, up};
      if (m[24]) begin
        m = m >> 1;
        p = p + 1;
      end
    end
    return {inx, neg, 8'(p + 127), m[22:0]};
  endfunction

  task automatic step(input bit v, input logic [31:0] d, input bit s, input bit rm, input bit ordy,
                      output bit acc, output bit ov, output logic [32:0] obs);
    @(negedge clk);
    bus32.in_valid  = v;
    bus32.in_data   = d;
    bus32.in_signed = s;
    bus32.in_rm     = rm;
    bus32.out_ready = ordy;
    #1;
    acc = v && bus32.in_ready;
    ov  = bus32.out_valid;
    obs = {1'b0, bus32.out_fp};
`ifdef FP_CVT_INEXACT_EN
    obs[32] = bus32.out_inexact;
`endif
    if (acc) exp_q.push_back(model({32'd0, d}, 32, s, rm));
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b0 || bus32.out_fp !== 32'd0)
      begin failures++; $display("FAIL reset_hold: valid=%b ready=%b fp=%h, required 0 0 00000000",
                                 bus32.out_valid, bus32.in_ready, bus32.out_fp); end
`ifdef FP_CVT_INEXACT_EN
    checks++;
    if (bus32.out_inexact !== 1'b0)
      begin failures++; $display("FAIL reset_inexact: got %b, required 0", bus32.out_inexact); end
`endif
    checks++;
    if (bus8.out_valid !== 1'b0 || bus64.out_valid !== 1'b0)
      begin failures++; $display("FAIL reset_widths: valid8=%b valid64=%b, required 0 0", bus8.out_valid, bus64.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0)
      begin failures++; $display("FAIL reset_release: ready=%b valid=%b, required 1 0", bus32.in_ready, bus32.out_valid); end
  endtask

  task automatic test_directed();
    vec_t vecs[10];
    bit acc, ov, found;
    logic [32:0] obs;
    int lat;
    vecs[0] = '{32'h0000_0001, 1'b1, 1'b0, {1'b0, 32'h3f80_0000}};
    vecs[1] = '{32'hffff_ffff, 1'b1, 1'b0, {1'b0, 32'hbf80_0000}};
    vecs[2] = '{32'h0000_0000, 1'b1, 1'b0, {1'b0, 32'h0000_0000}};
    vecs[3] = '{32'h8000_0000, 1'b1, 1'b0, {1'b0, 32'hcf00_0000}};
    vecs[4] = '{32'h8000_0000, 1'b0, 1'b0, {1'b0, 32'h4f00_0000}};
    vecs[5] = '{32'h7fff_ffff, 1'b1, 1'b0, {1'b1, 32'h4f00_0000}};
    vecs[6] = '{32'h7fff_ffff, 1'b1, 1'b1, {1'b1, 32'h4eff_ffff}};
    vecs[7] = '{32'h0100_0001, 1'b1, 1'b0, {1'b1, 32'h4b80_0000}};
    vecs[8] = '{32'h0100_0003, 1'b1, 1'b0, {1'b1, 32'h4b80_0002}};
    vecs[9] = '{32'h00ff_efff, 1'b1, 1'b0, {1'b0, 32'h4b7f_efff}};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].d, vecs[i].s, vecs[i].rm, 1'b1, acc, ov, obs);
      checks++;
      if (!acc) begin failures++; $display("FAIL dir_accept[%0d]: in_ready=0, required 1", i); end
      found = 1'b0;
      lat   = 0;
      for (int k = 1; k <= 8 && !found; k++) begin
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc, ov, obs);
        if (ov) begin found = 1'b1; lat = k; end
      end
      checks++;
      if (!found) begin
        failures++; $display("FAIL dir_timeout[%0d]: no out_valid within 8 cycles", i);
      end else begin
        checks++;
        if ((obs & CMP_MASK) !== (vecs[i].e & CMP_MASK))
          begin failures++; $display("FAIL dir_value[%0d] in=%h: got %h, required %h", i, vecs[i].d, obs, vecs[i].e & CMP_MASK); end
        checks++;
        if (lat != 3)
          begin failures++; $display("FAIL dir_latency[%0d]: got %0d cycles, required 3", i, lat); end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_width();
    logic [7:0]  d8[2];
    bit          s8[2];
    logic [31:0] e8[2];
    logic [31:0] got;
    bit          found;
    d8[0] = 8'h80; s8[0] = 1'b1; e8[0] = 32'hc300_0000;
    d8[1] = 8'hff; s8[1] = 1'b0; e8[1] = 32'h437f_0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b1; bus8.in_data = d8[i]; bus8.in_signed = s8[i]; bus8.in_rm = 1'b0; bus8.out_ready = 1'b1;
      #1;
      checks++;
      if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL w8_accept[%0d]: in_ready=0, required 1", i); end
      @(negedge clk);
      bus8.in_valid = 1'b0;
      found = 1'b0; got = '0;
      for (int k = 0; k < 8 && !found; k++) begin
        #1;
        if (bus8.out_valid) begin found = 1'b1; got = bus8.out_fp; end
        else @(negedge clk);
      end
      checks++;
      if (!found || got !== e8[i])
        begin failures++; $display("FAIL w8_value[%0d]: got %h (valid=%b), required %h", i, got, found, e8[i]); end
    end
    @(negedge clk);
    bus64.in_valid = 1'b1; bus64.in_data = '1; bus64.in_signed = 1'b0; bus64.in_rm = 1'b0; bus64.out_ready = 1'b1;
    #1;
    checks++;
    if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL w64_accept: in_ready=0, required 1"); end
    @(negedge clk);
    bus64.in_valid = 1'b0;
    found = 1'b0; got = '0;
    for (int k = 0; k < 8 && !found; k++) begin
      #1;
      if (bus64.out_valid) begin found = 1'b1; got = bus64.out_fp; end
      else @(negedge clk);
    end
    checks++;
    if (!found || got !== 32'h5f80_0000)
      begin failures++; $display("FAIL w64_value: got %h (valid=%b), required 5f800000", got, found); end
`ifdef FP_CVT_INEXACT_EN
    checks++;
    if (bus64.out_inexact !== 1'b1)
      begin failures++; $display("FAIL w64_inexact: got %b, required 1", bus64.out_inexact); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] d[6];
    bit          s[6];
    bit          acc, ov, ordy, dup;
    logic [32:0] obs, e;
    logic [31:0] held;
    int idx, nout;
    idx = 0; nout = 0; held = '0;
    for (int i = 0; i < 6; i++) begin d[i] = $urandom; s[i] = 1'($urandom_range(0, 1)); end
    for (int k = 0; k < 40 && nout < 6; k++) begin
      ordy = (k >= 5);
      if (idx < 6) step(1'b1, d[idx], s[idx], 1'b0, ordy, acc, ov, obs);
      else         step(1'b0, 32'd0, 1'b0, 1'b0, ordy, acc, ov, obs);
      if (acc) idx++;
      if (k == 3) held = obs[31:0];
      if (k == 4) begin
        checks++;
        if (idx != 3 || bus32.in_ready !== 1'b0)
          begin failures++; $display("FAIL bb_inready: accepted=%0d ready=%b, required 3 0", idx, bus32.in_ready); end
      end
      if (k == 4 || k == 5) begin
        checks++;
        if (!ov || obs[31:0] !== held)
          begin failures++; $display("FAIL bb_stable k=%0d: got %h valid=%b, required %h valid=1", k, obs[31:0], ov, held); end
      end
      if (ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bb_extra: unexpected result %h", obs);
        end else begin
          e = exp_q.pop_front();
          if ((obs & CMP_MASK) !== (e & CMP_MASK))
            begin failures++; $display("FAIL bb_value[%0d]: got %h, required %h", nout, obs, e & CMP_MASK); end
        end
        nout++;
      end
    end
    checks++;
    if (nout != 6 || idx != 6)
      begin failures++; $display("FAIL bb_count: accepted=%0d results=%0d, required 6 6", idx, nout); end
    dup = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc, ov, obs);
      if (ov) dup = 1'b1;
    end
    checks++;
    if (dup || exp_q.size() != 0)
      begin failures++; $display("FAIL bb_dup: extra_valid=%b pending=%0d, required 0 0", dup, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    bit acc, ov, seen;
    logic [32:0] obs;
    int nacc;
    nacc = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, $urandom, 1'b1, 1'b0, 1'b0, acc, ov, obs);
      if (acc) nacc++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (nacc != 3 || bus32.out_valid !== 1'b1)
      begin failures++; $display("FAIL rm_prefill: accepted=%0d valid=%b, required 3 1", nacc, bus32.out_valid); end
    bus32.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b0)
      begin failures++; $display("FAIL rm_async: valid=%b ready=%b, required 0 0", bus32.out_valid, bus32.in_ready); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc, ov, obs);
      if (ov) seen = 1'b1;
    end
    checks++;
    if (seen || bus32.in_ready !== 1'b1)
      begin failures++; $display("FAIL rm_stale: stale_valid=%b ready=%b, required 0 1", seen, bus32.in_ready); end
  endtask

  task automatic test_throughput();
    bit acc, ov, s, rm;
    logic [32:0] obs, e;
    logic [31:0] r, d;
    int idx, nout, gaps, stalls, first;
    idx = 0; nout = 0; gaps = 0; stalls = 0; first = -1;
    for (int k = 0; k < 200 && nout < 100; k++) begin
      if (idx < 100) begin
        r = $urandom;
        case ($urandom_range(0, 3))
          0:       d = r;
          1:       d = r >> $urandom_range(1, 31);
          2:       d = r | 32'h8000_0000;
          default: d = r & 32'h01ff_ffff;
        endcase
        s  = 1'($urandom_range(0, 1));
        rm = 1'($urandom_range(0, 1));
        step(1'b1, d, s, rm, 1'b1, acc, ov, obs);
        if (acc) idx++; else stalls++;
      end else begin
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc, ov, obs);
      end
      if (ov) begin
        if (first < 0) first = k;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL tp_extra: unexpected result %h", obs);
        end else begin
          e = exp_q.pop_front();
          if ((obs & CMP_MASK) !== (e & CMP_MASK))
            begin failures++; $display("FAIL tp_value[%0d]: got %h, required %h", nout, obs, e & CMP_MASK); end
        end
        nout++;
      end else if (first >= 0) begin
        gaps++;
      end
    end
    checks++;
    if (nout != 100 || exp_q.size() != 0)
      begin failures++; $display("FAIL tp_count: results=%0d pending=%0d, required 100 0", nout, exp_q.size()); end
    checks++;
    if (gaps != 0 || stalls != 0 || first != 3)
      begin failures++; $display("FAIL tp_rate: gaps=%0d stalls=%0d first=%0d, required 0 0 3", gaps, stalls, first); end
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_signed = 1'b0; bus32.in_rm = 1'b0; bus32.out_ready = 1'b1;
    bus8.in_valid  = 1'b0; bus8.in_data  = '0; bus8.in_signed  = 1'b0; bus8.in_rm  = 1'b0; bus8.out_ready  = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_signed = 1'b0; bus64.in_rm = 1'b0; bus64.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_width();
    test_back_to_back();
    test_reset_midstream();
    test_throughput();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
